// File: rtl/gpu_irq_receiver.sv
// rtl/gpu_irq_receiver.sv - IRQ pulse collector presenting one enabled source at a time to the CPU
//
// Ports:
//   clk         : clock, all state updates on the rising edge
//   n_rst       : asynchronous active-low reset
//   irq_i       : one-cycle IRQ pulses, one bit per source
//   mask_wr_i   : write strobe for the enable register
//   mask_i      : enable value written on mask_wr_i (1 = enabled)
//   ack_i       : one-cycle CPU acknowledge of the presented IRQ
//   drop_clr_i  : synchronous clear of the dropped-event counter
//   cpu_irq_o   : registered level interrupt to the CPU
//   irq_id_o    : index of the presented source
//   pending_o   : pending register, independent of the enable mask
//   drop_cnt_o  : saturating count of pulses lost to an already-pending bit

module gpu_irq_receiver #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_SRC-1:0]         irq_i,
    input  logic                       mask_wr_i,
    input  logic [NUM_SRC-1:0]         mask_i,
    input  logic                       ack_i,
    input  logic                       drop_clr_i,
    output logic                       cpu_irq_o,
    output logic [$clog2(NUM_SRC)-1:0] irq_id_o,
    output logic [NUM_SRC-1:0]         pending_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam int ID_W  = $clog2(NUM_SRC);
    // Five extra bits hold a per-cycle increment of up to 16 sources.
    localparam int SUM_W = CNT_W + 5;
    localparam logic [SUM_W-1:0] CNT_MAX = {{5{1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q;
    logic               cpu_irq_q, cpu_irq_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [NUM_SRC-1:0] req;
    logic [ID_W-1:0]    low_idx;
    logic               ack_take;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] drop_vec;
    logic [4:0]         drop_inc;
    logic [SUM_W-1:0]   drop_sum;

    assign req = pending_q & enable_q;

    // Lowest-numbered requesting source wins; scanning downward lets the
    // last assignment be the lowest index.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = ID_W'(i);
            end
        end
    end

    // Presentation FSM.
    always_comb begin
        state_d   = state_q;
        cpu_irq_d = cpu_irq_q;
        irq_id_d  = irq_id_q;
        ack_take  = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_irq_d = 1'b0;
                if (|req) begin
                    state_d   = ASSERT;
                    cpu_irq_d = 1'b1;
                    irq_id_d  = low_idx;
                end
            end
            ASSERT: begin
                if (ack_i) begin
                    ack_take  = 1'b1;
                    state_d   = GAP;
                    cpu_irq_d = 1'b0;
                end else if (!enable_q[irq_id_q]) begin
                    // Source masked off while presented: withdraw but keep it pending.
                    state_d   = IDLE;
                    cpu_irq_d = 1'b0;
                end
            end
            GAP: begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
    end

    // An acknowledged source is cleared, but a fresh pulse on the same cycle
    // re-sets it; that pulse is not a drop because the old event was consumed.
    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[irq_id_q] = 1'b1;
        end
    end

    assign pending_d = (pending_q & ~ack_clr) | irq_i;
    assign drop_vec  = irq_i & pending_q & ~ack_clr;

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_inc = drop_inc + {4'b0000, drop_vec[i]};
        end
    end

    assign drop_sum = {5'b00000, drop_cnt_q} + {{(SUM_W-5){1'b0}}, drop_inc};

    always_comb begin
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (drop_sum > CNT_MAX) begin
            drop_cnt_d = {CNT_W{1'b1}};
        end else begin
            drop_cnt_d = drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            enable_q   <= '0;
            cpu_irq_q  <= 1'b0;
            irq_id_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cpu_irq_q  <= cpu_irq_d;
            irq_id_q   <= irq_id_d;
            drop_cnt_q <= drop_cnt_d;
            if (mask_wr_i) begin
                enable_q <= mask_i;
            end
        end
    end

    assign cpu_irq_o  = cpu_irq_q;
    assign irq_id_o   = irq_id_q;
    assign pending_o  = pending_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_gpu_irq_receiver.sv
// tb/tb_gpu_irq_receiver.sv - randomized and directed bench for gpu_irq_receiver against a reference model

module tb_gpu_irq_receiver;

    localparam int N = 4;

    logic         clk;
    logic         n_rst;
    logic [N-1:0] irq;
    logic         mask_wr;
    logic [N-1:0] mask;
    logic         ack;
    logic         drop_clr;

    logic         cpu_irq;
    logic [1:0]   irq_id;
    logic [N-1:0] pending;
    logic [7:0]   drop_cnt;

    logic         cpu_irq2;
    logic [1:0]   irq_id2;
    logic [N-1:0] pending2;
    logic [1:0]   drop_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    bit [N-1:0] m_pend;
    bit [N-1:0] m_en;
    bit         m_irq;
    bit         m_gap;
    int         m_id;
    int         m_drop;
    int         m_drop2;

    gpu_irq_receiver #(.NUM_SRC(N), .CNT_W(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .irq_i      (irq),
        .mask_wr_i  (mask_wr),
        .mask_i     (mask),
        .ack_i      (ack),
        .drop_clr_i (drop_clr),
        .cpu_irq_o  (cpu_irq),
        .irq_id_o   (irq_id),
        .pending_o  (pending),
        .drop_cnt_o (drop_cnt)
    );

    gpu_irq_receiver #(.NUM_SRC(N), .CNT_W(2)) dut2 (
        .clk        (clk),
        .n_rst      (n_rst),
        .irq_i      (irq),
        .mask_wr_i  (mask_wr),
        .mask_i     (mask),
        .ack_i      (ack),
        .drop_clr_i (drop_clr),
        .cpu_irq_o  (cpu_irq2),
        .irq_id_o   (irq_id2),
        .pending_o  (pending2),
        .drop_cnt_o (drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_en    = '0;
        m_irq   = 1'b0;
        m_gap   = 1'b0;
        m_id    = 0;
        m_drop  = 0;
        m_drop2 = 0;
    endtask

    // One clock of behaviour, from the inputs present before the edge.
    task automatic model_step();
        int         drops;
        bit         ack_taken;
        bit [N-1:0] np;
        drops     = 0;
        ack_taken = m_irq && ack;
        for (int i = 0; i < N; i++) begin
            bit consumed;
            consumed = ack_taken && (i == m_id);
            if (irq[i] && m_pend[i] && !consumed) drops++;
            np[i] = irq[i] || (m_pend[i] && !consumed);
        end
        if (m_irq) begin
            if (ack) begin
                m_irq = 1'b0;
                m_gap = 1'b1;
            end else if (!m_en[m_id]) begin
                m_irq = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_en[i] && !m_irq) begin
                    m_irq = 1'b1;
                    m_id  = i;
                end
            end
        end
        m_pend = np;
        if (mask_wr) m_en = mask;
        if (drop_clr) begin
            m_drop  = 0;
            m_drop2 = 0;
        end else begin
            m_drop  = (m_drop + drops > 255) ? 255 : m_drop + drops;
            m_drop2 = (m_drop2 + drops > 3) ? 3 : m_drop2 + drops;
        end
    endtask

    task automatic compare_all();
        check("cpu_irq",   32'(cpu_irq),   32'(m_irq));
        check("irq_id",    32'(irq_id),    32'(m_id));
        check("pending",   32'(pending),   32'(m_pend));
        check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        check("cpu_irq2",  32'(cpu_irq2),  32'(m_irq));
        check("irq_id2",   32'(irq_id2),   32'(m_id));
        check("pending2",  32'(pending2),  32'(m_pend));
        check("drop_cnt2", 32'(drop_cnt2), 32'(m_drop2));
    endtask

    task automatic clear_inputs();
        irq      = '0;
        mask_wr  = 1'b0;
        mask     = '0;
        ack      = 1'b0;
        drop_clr = 1'b0;
    endtask

    // Apply current inputs over one edge, compare on the falling edge, then idle inputs.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        clear_inputs();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_irq",  32'(cpu_irq),  32'd0);
        check("rst_pending",  32'(pending),  32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_irq_id",   32'(irq_id),   32'd0);
        n_rst = 1'b1;
        step();

        // Single source: pulse on 2 -> pending next cycle, IRQ the cycle after.
        mask_wr = 1'b1; mask = 4'b1111; step();
        irq = 4'b0100; step();
        check("s1_pending", 32'(pending), 32'h4);
        check("s1_cpu_lo",  32'(cpu_irq), 32'd0);
        step();
        check("s1_cpu_hi",  32'(cpu_irq), 32'd1);
        check("s1_id",      32'(irq_id),  32'd2);
        ack = 1'b1; step();
        check("s1_ack_pend", 32'(pending), 32'h0);
        check("s1_ack_cpu",  32'(cpu_irq), 32'd0);
        step();
        check("s1_gap_cpu",  32'(cpu_irq), 32'd0);

        // Presented id is held while a lower source arrives.
        irq = 4'b1000; step(); step();
        check("s2_id3", 32'(irq_id), 32'd3);
        irq = 4'b0001; step();
        check("s2_hold_id", 32'(irq_id),  32'd3);
        check("s2_hold_cpu", 32'(cpu_irq), 32'd1);
        step();
        ack = 1'b1; step();
        check("s2_ack_cpu", 32'(cpu_irq), 32'd0);
        step();
        step();
        check("s2_next_cpu", 32'(cpu_irq), 32'd1);
        check("s2_next_id",  32'(irq_id),  32'd0);
        ack = 1'b1; step(); steps(2);

        // Masked source stays pending, presented two cycles after the enable write.
        mask_wr = 1'b1; mask = 4'b0000; step();
        irq = 4'b0010; step(); step();
        check("s3_cpu_lo",  32'(cpu_irq), 32'd0);
        check("s3_pending", 32'(pending), 32'h2);
        mask_wr = 1'b1; mask = 4'b0010; step();
        step();
        check("s3_cpu_hi", 32'(cpu_irq), 32'd1);
        check("s3_id",     32'(irq_id),  32'd1);
        // Disabling the presented source withdraws it without clearing pending.
        mask_wr = 1'b1; mask = 4'b0000; step();
        step();
        check("s3_withdraw_cpu",  32'(cpu_irq), 32'd0);
        check("s3_withdraw_pend", 32'(pending), 32'h2);
        ack = 1'b1; step();
        check("s3_idle_ack_pend", 32'(pending), 32'h2);

        // Drop counter, saturation of the 2-bit instance and clear priority.
        drop_clr = 1'b1; step();
        mask_wr = 1'b1; mask = 4'b0000; step();
        for (int k = 0; k < 3; k++) begin irq = 4'b0010; step(); end
        check("s4_drop2", 32'(drop_cnt),  32'd3);
        for (int k = 0; k < 7; k++) begin irq = 4'b0010; step(); end
        check("s4_drop9",  32'(drop_cnt),  32'd10);
        check("s4_sat2",   32'(drop_cnt2), 32'd3);
        irq = 4'b0010; drop_clr = 1'b1; step();
        check("s4_clr",    32'(drop_cnt),  32'd0);
        check("s4_clr2",   32'(drop_cnt2), 32'd0);
        // pending[1] was already set before the block started, so three
        // pulses are three drops; restart cleanly for the exact case.
        mask_wr = 1'b1; mask = 4'b0010; step(); step();
        ack = 1'b1; step(); steps(2);
        mask_wr = 1'b1; mask = 4'b0000; drop_clr = 1'b1; step();
        for (int k = 0; k < 3; k++) begin irq = 4'b0010; step(); end
        check("s4_exact2", 32'(drop_cnt), 32'd2);
        drop_clr = 1'b1; step();
        check("s4_clr_b", 32'(drop_cnt), 32'd0);
        mask_wr = 1'b1; mask = 4'b0010; step(); step();
        ack = 1'b1; step(); steps(2);

        // Ack coinciding with a new pulse on the presented source.
        mask_wr = 1'b1; mask = 4'b1111; step();
        irq = 4'b0100; step(); step();
        check("s5_id", 32'(irq_id), 32'd2);
        ack = 1'b1; irq = 4'b0100; step();
        check("s5_pend_kept", 32'(pending),  32'h4);
        check("s5_no_drop",   32'(drop_cnt), 32'd0);
        check("s5_cpu_lo",    32'(cpu_irq),  32'd0);
        step(); step();
        check("s5_repres_cpu", 32'(cpu_irq), 32'd1);
        check("s5_repres_id",  32'(irq_id),  32'd2);
        ack = 1'b1; step(); steps(2);

        // Asynchronous reset while the IRQ is high.
        irq = 4'b0001; step(); step();
        check("s6_cpu_hi", 32'(cpu_irq), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("s6_async_cpu",  32'(cpu_irq),  32'd0);
        check("s6_async_pend", 32'(pending),  32'd0);
        check("s6_async_id",   32'(irq_id),   32'd0);
        check("s6_async_drop", 32'(drop_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        mask_wr = 1'b1; mask = 4'b1111; step();
        steps(3);
        check("s6_quiet", 32'(cpu_irq), 32'd0);
        irq = 4'b0001; step(); step();
        check("s6_new_irq", 32'(cpu_irq), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) irq[b] = ($urandom_range(3) == 0);
            ack      = ($urandom_range(2) == 0);
            mask_wr  = ($urandom_range(15) == 0);
            mask     = N'($urandom);
            drop_clr = ($urandom_range(60) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_irq_receiver.md
GPU_IRQ_RECEIVER -- requirements
Module: gpu_irq_receiver

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of IRQ pulse sources (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the dropped-event counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_i  input  NUM_SRC  one-cycle IRQ pulses, one bit per source.
REQ-006 SHALL have port mask_wr_i  input  1  write strobe for the enable register.
REQ-007 SHALL have port mask_i  input  NUM_SRC  enable value written on mask_wr_i; 1 = enabled.
REQ-008 SHALL have port ack_i  input  1  one-cycle CPU acknowledge of the presented IRQ.
REQ-009 SHALL have port drop_clr_i  input  1  synchronous clear of the dropped-event counter.
REQ-010 SHALL have port cpu_irq_o  output  1  registered level interrupt to the CPU.
REQ-011 SHALL have port irq_id_o  output  $clog2(NUM_SRC)  index of the presented source.
REQ-012 SHALL have port pending_o  output  NUM_SRC  pending register, regardless of mask.
REQ-013 SHALL have port drop_cnt_o  output  CNT_W  count of events lost to an already-pending bit.

Function
REQ-014 SHALL set pending[i] on any cycle irq_i[i]=1, whether or not enable[i] is set.
REQ-015 SHALL load enable from mask_i on mask_wr_i=1; the new value takes effect the next cycle.
REQ-016 SHALL implement FSM states IDLE, ASSERT, GAP.
REQ-017 SHALL, in IDLE, when (pending & enable) != 0, latch the lowest-numbered such index into irq_id_o, set cpu_irq_o=1 and go to ASSERT; cpu_irq_o rises exactly 1 cycle after the pending bit is visible.
REQ-018 SHALL hold irq_id_o and cpu_irq_o=1 stable in ASSERT until ack_i, even if a lower-numbered source becomes pending.
REQ-019 SHALL, on ack_i in ASSERT, clear pending[irq_id_o], drive cpu_irq_o=0 and go to GAP.
REQ-020 SHALL stay in GAP exactly one cycle with cpu_irq_o=0, then return to IDLE, guaranteeing a falling edge between back-to-back IRQs.
REQ-021 SHALL ignore ack_i in IDLE and GAP (no pending bit cleared).
REQ-022 SHALL, if enable[irq_id_o] is cleared while in ASSERT, drop cpu_irq_o to 0 and go to IDLE without clearing pending[irq_id_o].
REQ-023 SHALL keep pending[irq_id_o] set when irq_i[irq_id_o] pulses in the same cycle as the ack, and SHALL NOT count it as dropped.
REQ-024 SHALL increment drop_cnt_o by the number of bits with irq_i[i]=1 and pending[i] already 1, excluding REQ-023 cases; drop_cnt_o saturates at 2^CNT_W-1.
REQ-025 SHALL give drop_clr_i priority over a same-cycle increment (result 0).
REQ-026 SHALL drive pending_o, cpu_irq_o, irq_id_o and drop_cnt_o directly from registers.

Reset
REQ-027 SHALL, while n_rst=0, force state IDLE, pending=0, enable=0, cpu_irq_o=0, irq_id_o=0 and drop_cnt_o=0, independent of clk.
REQ-028 SHALL, on reset mid-ASSERT, drop cpu_irq_o immediately and discard all pending events; the first clk edge after release begins in IDLE.

Verification
REQ-029 Bench SHALL cover: enable=4'b1111, pulse irq_i[2] at cycle N -> pending_o=4'b0100 at N+1, cpu_irq_o=1 and irq_id_o=2 at N+2; ack -> pending_o=0, cpu_irq_o=0 for at least 1 cycle.
REQ-030 Bench SHALL cover: irq_i[3] pulses, then irq_i[0] pulses while in ASSERT -> irq_id_o stays 3 until ack; after the GAP cycle, irq_id_o=0 and cpu_irq_o=1.
REQ-031 Bench SHALL cover: enable=0, pulse irq_i[1] -> cpu_irq_o stays 0 and pending_o=4'b0010; write mask_i=4'b0010 -> cpu_irq_o=1 and irq_id_o=1 two cycles after the write.
REQ-032 Bench SHALL cover: irq_i[1] pulsed 3 times with no ack -> drop_cnt_o=2; with CNT_W=2, 10 repeats -> drop_cnt_o=3; drop_clr_i -> 0.
REQ-033 Bench SHALL cover: ack_i and irq_i[irq_id_o] in the same cycle -> pending bit remains 1, drop_cnt_o unchanged, and the IRQ is re-presented after GAP.
REQ-034 Bench SHALL cover: n_rst asserted between clk edges while cpu_irq_o=1 -> all outputs 0 asynchronously; no IRQ after release until a new pulse.
